bv8_basis_pipe: RTL and testbench
=================================

Name: bv8_basis_pipe

Overview:
- Elastic, pipelined, share-wise 8-bit GF(2)-linear basis-change unit for the back end of the masked AES Sbox.
- Applies either the forward back-basis matrix (encryption) or its inverse (decryption), selected per beat, to each of NUM_SHARES Boolean shares independently.
- Sits between the masked inversion core and the MixColumns/state-register path.
- Uses a valid/ready handshake with programmable pipeline depth and a synchronous flush.

Parameters:
- NUM_SHARES, 2, number of Boolean shares per beat (>=1).
- STAGES, 2, number of register stages, 1..4; latency in cycles when not stalled.

Ports:
- in_clock  input  1  clock; all state updates on rising edge.
- in_reset  input  1  synchronous, active-high reset.
- in_flush  input  1  synchronous pipeline clear; drops all in-flight beats.
- in_valid  input  1  upstream beat valid.
- out_ready  output  1  unit can accept a beat this cycle.
- in_mode  input  1  0 = forward matrix, 1 = inverse matrix; sampled with the beat.
- in_x  input  NUM_SHARES*8  shares; share i at bits [8i+7:8i].
- out_valid  output  1  downstream beat valid.
- in_ready  input  1  downstream accepts beat.
- out_y  output  NUM_SHARES*8  transformed shares, same packing.

Behaviour:
- Matrices, bit k of a share:
  - Forward: y0=x1^x4^x6; y1=x1^x4^x5; y2=x0^x2^x3^x5^x6; y3=x3^x4^x5^x6^x7; y4=x3^x5^x7; y5=x0^x6; y6=x3^x7; y7=x3^x5.
  - Inverse: x0=y0^y1^y4^y5^y6; x1=y0^y3^y4; x2=y2^y5^y7; x3=y4^y6^y7; x4=y0^y1^y3^y6; x5=y4^y6; x6=y0^y1^y4^y6; x7=y4^y7.
- Linearity and masking:
  - No affine constant is applied.
  - Each share is transformed alone; shares never mix in any gate or register.
- Transform placement:
  - The transform is applied combinationally before stage 0.
  - Stages 1..STAGES-1 are pure delay registers.
  - Each stage holds valid, mode and data.
- Accept: a beat enters stage 0 when in_valid && out_ready.
- Stage advance:
  - Stage s (s < last) loads from stage s-1 when stage s is empty or stage s itself advances.
  - The last stage advances when in_ready is high.
  - out_ready = !v[0] || stage 0 advances (full-rate; no bubbles under continuous ready).
- Latency and ordering:
  - Accept at cycle t, with no stall, gives out_valid at cycle t+STAGES.
  - Beats leave in acceptance order.
  - Throughput is 1 beat/cycle.
- Stall: while out_valid && !in_ready, out_y and out_valid hold stable. This is a verification assertion.
- Full pipeline with in_ready low:
  - out_ready goes low after STAGES beats are in flight.
  - No beat is overwritten or lost.
- Simultaneous accept and emit with a full pipe and in_ready high: both occur in the same cycle; occupancy is unchanged.
- Reset:
  - in_reset high clears all valid bits and zeroes all data and mode registers (no stale share material).
  - out_valid=0, out_y=0, out_ready=0 during reset; out_ready=1 the first cycle after reset.
  - Reset mid-operation discards all in-flight beats.
- Flush:
  - in_flush high clears all valid bits; data registers are zeroed.
  - No beat is accepted in a flush cycle; out_ready=0 that cycle.
  - in_reset has priority over in_flush.
- Mode: taken per beat; changing in_mode between beats is legal; in-flight beats keep their sampled mode.

Decomposition:
- aes128_package additions:
  - bv8_t reused.
  - typedef enum logic {BASIS_FWD=0, BASIS_INV=1} basis_mode_t.
  - localparam MAX_BASIS_STAGES=4.
- Sub-module bv8_basis_mode: combinational single-share forward/inverse matrices plus mode mux, instantiated NUM_SHARES times.
- Elastic stage chain stays in the top module.

Test Plan:
- Forward, NUM_SHARES=1, STAGES=2: single beats 0x01, 0x80, 0xFF, mode=0 -> out_y 0x24, 0x58, 0x1F, each 2 cycles after accept.
- Inverse round trip: mode=1, beats 0x24, 0x58, 0x1F -> 0x01, 0x80, 0xFF. Random 1000 beats: fwd then inv returns the original.
- Masking, NUM_SHARES=2: shares {0x5A, 0x5B} (unmasked 0x01), mode=0 -> XOR of out shares = 0x24, and each out share equals fwd(its own share).
- Backpressure, STAGES=3: in_ready low for 10 cycles with in_valid continuously high -> exactly 3 beats accepted, out_ready low, out_y stable. Release -> beats emerge in order at 1/cycle.
- Flush/reset mid-stream: 2 beats in flight, in_flush pulsed -> out_valid stays 0 and those beats never appear. Repeat with in_reset -> all outputs 0, out_ready=1 next cycle.
- Mode interleave plus random stall: alternate mode every beat with a random in_ready pattern -> a scoreboard matches per-beat mode and data with zero loss or duplication.

Source files
------------

// File: rtl/bv8_basis_pipe_pkg.sv
// Shared types and reference matrices for the back-basis change of the masked AES Sbox.
// Both matrices are GF(2)-linear with no affine constant, so each one can be applied share by share.
package bv8_basis_pipe_pkg;

   typedef logic [7:0] bv8_t;

   typedef enum logic {
      BASIS_FWD = 1'b0,
      BASIS_INV = 1'b1
   } basis_mode_t;

   localparam int MAX_BASIS_STAGES = 4;

   function automatic bv8_t basis_fwd(input bv8_t x);
      bv8_t y;
      y[0] = x[1] ^ x[4] ^ x[6];
      y[1] = x[1] ^ x[4] ^ x[5];
      y[2] = x[0] ^ x[2] ^ x[3] ^ x[5] ^ x[6];
      y[3] = x[3] ^ x[4] ^ x[5] ^ x[6] ^ x[7];
      y[4] = x[3] ^ x[5] ^ x[7];
      y[5] = x[0] ^ x[6];
      y[6] = x[3] ^ x[7];
      y[7] = x[3] ^ x[5];
      return y;
   endfunction

   function automatic bv8_t basis_inv(input bv8_t y);
      bv8_t x;
      x[0] = y[0] ^ y[1] ^ y[4] ^ y[5] ^ y[6];
      x[1] = y[0] ^ y[3] ^ y[4];
      x[2] = y[2] ^ y[5] ^ y[7];
      x[3] = y[4] ^ y[6] ^ y[7];
      x[4] = y[0] ^ y[1] ^ y[3] ^ y[6];
      x[5] = y[4] ^ y[6];
      x[6] = y[0] ^ y[1] ^ y[4] ^ y[6];
      x[7] = y[4] ^ y[7];
      return x;
   endfunction

endpackage

// File: rtl/bv8_basis_pipe_if.sv
// Valid/ready beat interface between the inversion core, the basis pipe and the state path.
interface bv8_basis_pipe_if
   import bv8_basis_pipe_pkg::*;
   #(parameter int NUM_SHARES = 2)
   ();

   logic                    in_valid;
   logic                    out_ready;
   basis_mode_t             in_mode;
   logic [NUM_SHARES*8-1:0] in_x;
   logic                    out_valid;
   logic                    in_ready;
   logic [NUM_SHARES*8-1:0] out_y;

   modport slave (
      input  in_valid, in_mode, in_x, in_ready,
      output out_ready, out_valid, out_y
   );

   modport master (
      output in_valid, in_mode, in_x, in_ready,
      input  out_ready, out_valid, out_y
   );

endinterface

// File: rtl/bv8_basis_mode.sv
// Single-share basis change: forward or inverse matrix selected by the beat's mode.
module bv8_basis_mode
   import bv8_basis_pipe_pkg::*;
(
   input  bv8_t        x,
   input  basis_mode_t mode,
   output bv8_t        y
);

   always_comb begin
      y = (mode == BASIS_INV) ? basis_inv(x) : basis_fwd(x);
   end

endmodule

// File: rtl/bv8_basis_pipe.sv
// Elastic share-wise basis-change pipeline: transform before stage 0, then pure delay stages.
// Each share has its own matrix instance and the data registers never combine shares.
module bv8_basis_pipe
   import bv8_basis_pipe_pkg::*;
   #(
      parameter int NUM_SHARES = 2,
      parameter int STAGES     = 2
   )
   (
      input logic             in_clock,
      input logic             in_reset,
      input logic             in_flush,
      bv8_basis_pipe_if.slave bus
   );

   localparam int W = NUM_SHARES * 8;

   if (STAGES < 1 || STAGES > MAX_BASIS_STAGES) begin : g_bad_stages
      $error("bv8_basis_pipe: STAGES out of range");
   end

   logic [W-1:0] xform;

   for (genvar i = 0; i < NUM_SHARES; i++) begin : g_share
      bv8_basis_mode u_mode (
         .x    (bus.in_x[8*i +: 8]),
         .mode (bus.in_mode),
         .y    (xform[8*i +: 8])
      );
   end

   logic         valid_q [STAGES];
   basis_mode_t  mode_q  [STAGES];
   logic [W-1:0] data_q  [STAGES];
   logic [STAGES-1:0] load_en;
   logic         accept;

   // A stage may load when downstream drains this cycle or any stage from here to the tail is empty.
   always_comb begin
      load_en = '0;
      for (int s = 0; s < STAGES; s++) begin
         load_en[s] = bus.in_ready;
         for (int k = s; k < STAGES; k++) begin
            if (!valid_q[k]) load_en[s] = 1'b1;
         end
      end
   end

   assign bus.out_ready = load_en[0] && !in_reset && !in_flush;
   assign accept        = bus.in_valid && bus.out_ready;

   always_ff @(posedge in_clock) begin
      if (in_reset || in_flush) begin
         for (int s = 0; s < STAGES; s++) begin
            valid_q[s] <= 1'b0;
            mode_q[s]  <= BASIS_FWD;
            data_q[s]  <= '0;
         end
      end else begin
         if (load_en[0]) begin
            valid_q[0] <= accept;
            mode_q[0]  <= accept ? bus.in_mode : BASIS_FWD;
            data_q[0]  <= accept ? xform : '0;
         end
         for (int s = 1; s < STAGES; s++) begin
            if (load_en[s]) begin
               valid_q[s] <= valid_q[s-1];
               mode_q[s]  <= mode_q[s-1];
               data_q[s]  <= data_q[s-1];
            end
         end
      end
   end

   // Reset blanks the outputs immediately so no share material is visible while it is held.
   assign bus.out_valid = valid_q[STAGES-1] && !in_reset;
   assign bus.out_y     = in_reset ? '0 : data_q[STAGES-1];

endmodule

// File: tb/tb_bv8_basis_pipe.sv
// Scoreboard bench for bv8_basis_pipe: expected shares are queued at acceptance and popped at emission.
module tb_bv8_basis_pipe;
   import bv8_basis_pipe_pkg::*;

   localparam int NUM_SHARES = 2;
   localparam int STAGES     = 3;
   localparam int W          = NUM_SHARES * 8;

   logic clock = 1'b0;
   logic reset;
   logic flush;

   always #5 clock = ~clock;

   bv8_basis_pipe_if #(.NUM_SHARES(NUM_SHARES)) bif ();

   bv8_basis_pipe #(.NUM_SHARES(NUM_SHARES), .STAGES(STAGES)) dut (
      .in_clock (clock),
      .in_reset (reset),
      .in_flush (flush),
      .bus      (bif)
   );

   int checkCount = 0;
   int errorCount = 0;
   logic [W-1:0] expQ [$];
   int readyMode = 0;
   logic prevHold = 1'b0;
   logic [W-1:0] prevY = '0;
   logic [W-1:0] lastY = '0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference matrix kept as row masks, independent of the RTL equations.
   function automatic bv8_t fwdRow(input int k);
      case (k)
         0:       return 8'h52;
         1:       return 8'h32;
         2:       return 8'h6D;
         3:       return 8'hF8;
         4:       return 8'hA8;
         5:       return 8'h41;
         6:       return 8'h88;
         default: return 8'h28;
      endcase
   endfunction

   function automatic bv8_t refFwd(input bv8_t x);
      bv8_t y;
      for (int k = 0; k < 8; k++) y[k] = ^(x & fwdRow(k));
      return y;
   endfunction

   function automatic bv8_t refInv(input bv8_t y);
      bv8_t r = '0;
      for (int c = 0; c < 256; c++) begin
         if (refFwd(8'(c)) == y) r = 8'(c);
      end
      return r;
   endfunction

   function automatic logic [W-1:0] refExpect(input logic [W-1:0] x, input basis_mode_t m);
      logic [W-1:0] r;
      for (int i = 0; i < NUM_SHARES; i++) begin
         r[8*i +: 8] = (m == BASIS_INV) ? refInv(x[8*i +: 8]) : refFwd(x[8*i +: 8]);
      end
      return r;
   endfunction

   always @(posedge clock) begin
      #1;
      if (readyMode == 2) bif.in_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: handshakes seen at the falling edge are the ones the next rising edge commits.
   always @(negedge clock) begin
      if (reset || flush) begin
         expQ.delete();
         prevHold = 1'b0;
      end else begin
         if (prevHold) begin
            checkOutput("stall_valid", 32'(bif.out_valid), 32'd1);
            checkOutput("stall_data", 32'(bif.out_y), 32'(prevY));
         end
         if (bif.out_valid && bif.in_ready) begin
            if (expQ.size() == 0) checkOutput("unexpected_beat", 32'(bif.out_y), 32'hDEAD);
            else checkOutput("beat_data", 32'(bif.out_y), 32'(expQ.pop_front()));
         end
         if (bif.in_valid && bif.out_ready) expQ.push_back(refExpect(bif.in_x, bif.in_mode));
         prevHold = bif.out_valid && !bif.in_ready;
         prevY    = bif.out_y;
      end
   end

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic waitDrain(input int maxCycles);
      int n = 0;
      while (expQ.size() != 0 && n < maxCycles) begin
         nextCycle();
         n++;
      end
      checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
   endtask

   task automatic sendSingle(input string tag, input logic [W-1:0] x, input basis_mode_t m,
                             input logic [W-1:0] expY);
      int lat;
      bif.in_valid = 1'b1;
      bif.in_x     = x;
      bif.in_mode  = m;
      @(negedge clock);
      checkOutput({tag, "_ready"}, 32'(bif.out_ready), 32'd1);
      nextCycle();
      bif.in_valid = 1'b0;
      lat = 1;
      while (!bif.out_valid && lat < 20) begin
         nextCycle();
         lat++;
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'(STAGES));
      checkOutput(tag, 32'(bif.out_y), 32'(expY));
      lastY = bif.out_y;
      nextCycle();
   endtask

   task automatic sendStream(input logic [W-1:0] x, input basis_mode_t m);
      int t = 0;
      logic got;
      bif.in_valid = 1'b1;
      bif.in_x     = x;
      bif.in_mode  = m;
      do begin
         @(negedge clock);
         got = bif.out_ready;
         nextCycle();
         t++;
      end while (!got && t < 100);
      if (!got) checkOutput("accept_timeout", 32'(got), 32'd1);
   endtask

   task automatic applyStimulus();
      int acc;
      int n;
      logic [W-1:0] x;
      logic [W-1:0] y;

      // Reset state
      reset = 1'b1;
      nextCycle();
      nextCycle();
      @(negedge clock);
      checkOutput("reset_valid", 32'(bif.out_valid), 32'd0);
      checkOutput("reset_y", 32'(bif.out_y), 32'd0);
      checkOutput("reset_ready", 32'(bif.out_ready), 32'd0);
      nextCycle();
      reset = 1'b0;
      @(negedge clock);
      checkOutput("after_reset_ready", 32'(bif.out_ready), 32'd1);
      nextCycle();

      // Known forward and inverse vectors
      sendSingle("fwd_01", 16'h0101, BASIS_FWD, 16'h2424);
      sendSingle("fwd_80", 16'h8080, BASIS_FWD, 16'h5858);
      sendSingle("fwd_ff", 16'hFF00, BASIS_FWD, 16'h1F00);
      sendSingle("inv_24", 16'h2424, BASIS_INV, 16'h0101);
      sendSingle("inv_58", 16'h0058, BASIS_INV, 16'h0080);
      sendSingle("inv_1f", 16'h1F1F, BASIS_INV, 16'hFFFF);

      // Masked pair whose unmasked value is 0x01
      sendSingle("mask_fwd", 16'h5B5A, BASIS_FWD, 16'hDDF9);
      checkOutput("mask_xor", 32'(lastY[15:8] ^ lastY[7:0]), 32'h24);

      // Backpressure: in_ready low, in_valid held high for 10 cycles
      bif.in_ready = 1'b0;
      bif.in_valid = 1'b1;
      bif.in_mode  = BASIS_FWD;
      acc = 0;
      n = 0;
      for (int c = 0; c < 10; c++) begin
         bif.in_x = {8'(8'h30 + n), 8'(8'h40 + n)};
         @(negedge clock);
         if (bif.out_ready) begin
            acc++;
            n++;
         end
         nextCycle();
      end
      checkOutput("bp_accepted", 32'(acc), 32'(STAGES));
      bif.in_x = {8'(8'h30 + n), 8'(8'h40 + n)};
      @(negedge clock);
      checkOutput("bp_ready_low", 32'(bif.out_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(bif.out_valid), 32'd1);
      nextCycle();
      bif.in_ready = 1'b1;
      @(negedge clock);
      checkOutput("full_pipe_ready", 32'(bif.out_ready), 32'd1);
      nextCycle();
      bif.in_valid = 1'b0;
      for (int c = 0; c < STAGES; c++) begin
         @(negedge clock);
         checkOutput("bp_rate", 32'(bif.out_valid), 32'd1);
         nextCycle();
      end
      waitDrain(20);

      // Flush with two beats in flight
      bif.in_valid = 1'b1;
      bif.in_x     = 16'h1111;
      nextCycle();
      bif.in_x     = 16'h2222;
      nextCycle();
      flush        = 1'b1;
      bif.in_x     = 16'h3333;
      @(negedge clock);
      checkOutput("flush_ready", 32'(bif.out_ready), 32'd0);
      nextCycle();
      flush        = 1'b0;
      bif.in_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         checkOutput("flush_gone", 32'(bif.out_valid), 32'd0);
         nextCycle();
      end

      // Reset with a stalled full pipe
      bif.in_ready = 1'b0;
      bif.in_valid = 1'b1;
      for (int c = 0; c < STAGES; c++) begin
         bif.in_x = {8'(8'hC0 + c), 8'(8'h0C + c)};
         nextCycle();
      end
      checkOutput("pre_reset_valid", 32'(bif.out_valid), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("midreset_valid", 32'(bif.out_valid), 32'd0);
      checkOutput("midreset_y", 32'(bif.out_y), 32'd0);
      checkOutput("midreset_ready", 32'(bif.out_ready), 32'd0);
      nextCycle();
      reset        = 1'b0;
      bif.in_valid = 1'b0;
      bif.in_ready = 1'b1;
      @(negedge clock);
      checkOutput("post_reset_ready", 32'(bif.out_ready), 32'd1);
      checkOutput("post_reset_y", 32'(bif.out_y), 32'd0);
      nextCycle();
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         checkOutput("reset_gone", 32'(bif.out_valid), 32'd0);
         nextCycle();
      end

      // Round trip with alternating mode per beat and random downstream stalls
      readyMode = 2;
      for (int i = 0; i < 500; i++) begin
         x = W'($urandom);
         y = refExpect(x, BASIS_FWD);
         sendStream(x, BASIS_FWD);
         sendStream(y, BASIS_INV);
      end
      bif.in_valid = 1'b0;
      readyMode    = 0;
      bif.in_ready = 1'b1;
      waitDrain(100);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset        = 1'b1;
      flush        = 1'b0;
      bif.in_valid = 1'b0;
      bif.in_ready = 1'b1;
      bif.in_mode  = BASIS_FWD;
      bif.in_x     = '0;
      #1;
      applyStimulus();
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
